spine_egress_scheduler: RTL and testbench

- Sits between the network interface egress (router GPU-input side) and the four spine output links of a group router.
- Accepts single-flit 16-bit packets over a valid/ready handshake and distributes them across spines 1-4 by credit-aware round-robin.
- Replaces the "router always ready" tie-off with real per-spine credit flow control, and reports credit and stall status.

---
 rtl/spine_egress_scheduler.sv | 135 +++++++++++++
 tb/tb_spine_egress_scheduler.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spine_egress_scheduler.sv
// Egress scheduler between the NI and the four spine links: one-flit hold
// register, credit-aware round-robin issue, per-spine credit and stall status.
module spine_egress_scheduler #(
  parameter int DWIDTH       = 16,
  parameter int INIT_CREDITS = 4,
  parameter int STALL_LIMIT  = 64
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic                enable,
  input  logic [3:0]          spine_mask,
  input  logic [DWIDTH-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [4*DWIDTH-1:0] spine_out_data,
  output logic [3:0]          spine_out_valid,
  input  logic [3:0]          credit_return,
  output logic [15:0]         credit_count,
  output logic [1:0]          last_grant,
  output logic                busy,
  output logic                stall_timeout,
  output logic                credit_overflow
);

  typedef enum logic {IDLE, HOLD} state_t;

  localparam logic [3:0] CREDIT_MAX = 4'(INIT_CREDITS);
  localparam logic [7:0] STALL_MAX  = 8'(STALL_LIMIT);

  state_t              state_q;
  logic [DWIDTH-1:0]   hold_q;
  logic [3:0]          credit_q [4];
  logic [3:0]          credit_d [4];
  logic [1:0]          last_grant_q;
  logic [7:0]          stall_q, stall_d;
  logic                stall_to_q;
  logic                ovf_q, ovf_d;
  logic [4*DWIDTH-1:0] out_data_q;
  logic [3:0]          out_valid_q;

  logic [3:0] elig;
  logic       found;
  logic [1:0] grant_idx;
  logic [1:0] cand;
  logic       issue;
  logic       accept;

  // Circular search starting one past the last granted spine.
  always_comb begin
    found     = 1'b0;
    grant_idx = last_grant_q;
    cand      = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      elig[i] = (credit_q[i] != '0) && !spine_mask[i];
    end
    for (int unsigned k = 1; k <= 4; k++) begin
      cand = last_grant_q + 2'(k);
      if (!found && elig[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign issue    = (state_q == HOLD) && found;
  assign in_ready = enable && ((state_q == IDLE) || issue);
  assign accept   = in_valid && in_ready;

  // Same-cycle issue and return cancel; a return at the ceiling is dropped.
  always_comb begin
    ovf_d = ovf_q;
    for (int unsigned i = 0; i < 4; i++) begin
      credit_d[i] = credit_q[i];
      if (credit_return[i] && !(issue && grant_idx == 2'(i))) begin
        if (credit_q[i] == CREDIT_MAX) ovf_d = 1'b1;
        else                           credit_d[i] = credit_q[i] + 4'd1;
      end else if (!credit_return[i] && issue && grant_idx == 2'(i)) begin
        credit_d[i] = credit_q[i] - 4'd1;
      end
    end
  end

  always_comb begin
    stall_d = '0;
    if (state_q == HOLD && !issue) begin
      stall_d = (stall_q == STALL_MAX) ? stall_q : stall_q + 8'd1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      last_grant_q <= 2'd3;
      stall_q      <= '0;
      stall_to_q   <= 1'b0;
      ovf_q        <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= '0;
      for (int unsigned i = 0; i < 4; i++) credit_q[i] <= CREDIT_MAX;
    end else begin
      out_valid_q <= '0;
      if (issue) begin
        out_valid_q[grant_idx] <= 1'b1;
        last_grant_q           <= grant_idx;
        for (int unsigned i = 0; i < 4; i++) begin
          if (grant_idx == 2'(i)) out_data_q[i*DWIDTH +: DWIDTH] <= hold_q;
        end
      end
      if (accept) begin
        hold_q  <= in_data;
        state_q <= HOLD;
      end else if (issue) begin
        state_q <= IDLE;
      end
      for (int unsigned i = 0; i < 4; i++) credit_q[i] <= credit_d[i];
      stall_q <= stall_d;
      if (stall_d == STALL_MAX) stall_to_q <= 1'b1;
      ovf_q <= ovf_d;
    end
  end

  always_comb begin
    credit_count = '0;
    for (int unsigned i = 0; i < 4; i++) credit_count[i*4 +: 4] = credit_q[i];
  end

  assign spine_out_data  = out_data_q;
  assign spine_out_valid = out_valid_q;
  assign last_grant      = last_grant_q;
  assign busy            = (state_q == HOLD);
  assign stall_timeout   = stall_to_q;
  assign credit_overflow = ovf_q;

endmodule

// File: tb/tb_spine_egress_scheduler.sv
// Bench for spine_egress_scheduler: directed scenarios plus a randomized run
// against a cycle-level reference model built from the scheduling rules.
module tb_spine_egress_scheduler;
  localparam int DW   = 16;
  localparam int INIT = 4;
  localparam int LIM  = 64;

  logic          ACLK = 1'b0;
  logic          ARESETn = 1'b0;
  logic          enable = 1'b0;
  logic [3:0]    spine_mask = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [4*DW-1:0] spine_out_data;
  logic [3:0]    spine_out_valid;
  logic [3:0]    credit_return = '0;
  logic [15:0]   credit_count;
  logic [1:0]    last_grant;
  logic          busy, stall_timeout, credit_overflow;

  spine_egress_scheduler #(.DWIDTH(DW), .INIT_CREDITS(INIT), .STALL_LIMIT(LIM)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .enable(enable), .spine_mask(spine_mask),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .spine_out_data(spine_out_data), .spine_out_valid(spine_out_valid),
    .credit_return(credit_return), .credit_count(credit_count),
    .last_grant(last_grant), .busy(busy), .stall_timeout(stall_timeout),
    .credit_overflow(credit_overflow)
  );

  always #5 ACLK = ~ACLK;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int            m_cr [4];
  bit            m_held;
  logic [DW-1:0] m_hd;
  int            m_lg, m_stall;
  bit            m_to, m_ov;
  logic [3:0]    m_vld;
  logic [DW-1:0] m_dat [4];

  function automatic int m_grant();
    for (int k = 1; k <= 4; k++) begin
      int j;
      j = (m_lg + k) % 4;
      if (m_cr[j] > 0 && !spine_mask[j]) return j;
    end
    return -1;
  endfunction

  function automatic bit m_ready();
    return enable && (!m_held || m_grant() >= 0);
  endfunction

  function automatic logic [15:0] m_credits();
    logic [15:0] w;
    w = '0;
    for (int i = 0; i < 4; i++) w[i*4 +: 4] = 4'(m_cr[i]);
    return w;
  endfunction

  function automatic logic [4*DW-1:0] m_data_word();
    logic [4*DW-1:0] w;
    for (int i = 0; i < 4; i++) w[i*DW +: DW] = m_dat[i];
    return w;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_cr[i]  = INIT;
      m_dat[i] = '0;
    end
    m_held = 0; m_hd = '0; m_lg = 3; m_stall = 0; m_to = 0; m_ov = 0; m_vld = '0;
  endtask

  // One clock edge; model advances from the inputs present at the edge.
  task automatic cycle();
    int g;
    bit iss, acc;
    logic [3:0] ret;
    logic [DW-1:0] d;
    g   = m_held ? m_grant() : -1;
    iss = (g >= 0);
    acc = in_valid && m_ready();
    ret = credit_return;
    d   = in_data;
    @(posedge ACLK); #1;
    m_vld = '0;
    if (iss) begin
      m_vld[g] = 1'b1;
      m_dat[g] = m_hd;
      m_lg     = g;
    end
    for (int i = 0; i < 4; i++) begin
      bit dec;
      dec = iss && (g == i);
      if (ret[i] && !dec) begin
        if (m_cr[i] == INIT) m_ov = 1;
        else m_cr[i]++;
      end else if (!ret[i] && dec) begin
        m_cr[i]--;
      end
    end
    if (m_held && !iss) begin
      if (m_stall < LIM) m_stall++;
      if (m_stall >= LIM) m_to = 1;
    end else begin
      m_stall = 0;
    end
    if (acc) begin
      m_held = 1; m_hd = d;
    end else if (iss) begin
      m_held = 0;
    end
  endtask

  task automatic apply_reset();
    @(negedge ACLK);
    ARESETn = 1'b0;
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    enable = 0; in_valid = 0; spine_mask = '0; credit_return = '0;
    apply_reset();
    #1;
    total++;
    if ({in_ready, spine_out_valid, busy, stall_timeout, credit_overflow} !== '0) begin
      bad++;
      $display("FAIL reset_ctrl: got ready=%b vld=%b busy=%b to=%b ov=%b, need all 0",
               in_ready, spine_out_valid, busy, stall_timeout, credit_overflow);
    end
    total++;
    if (spine_out_data !== '0) begin
      bad++; $display("FAIL reset_data: got %h need 0", spine_out_data);
    end
    total++;
    if (credit_count !== 16'h4444 || last_grant !== 2'd3) begin
      bad++; $display("FAIL reset_credit: got cc=%h lg=%0d need 4444/3", credit_count, last_grant);
    end
  endtask

  task automatic test_round_robin();
    logic [DW-1:0] fl [4];
    fl[0] = 16'h0401; fl[1] = 16'h0802; fl[2] = 16'h0C03; fl[3] = 16'h1004;
    enable = 1; in_valid = 1; in_data = fl[0];
    cycle();
    for (int k = 0; k < 4; k++) begin
      if (k < 3) in_data = fl[k+1];
      else in_valid = 0;
      cycle();
      total++;
      if (spine_out_valid !== 4'(1 << k) || spine_out_data[k*DW +: DW] !== fl[k]) begin
        bad++;
        $display("FAIL rr_issue%0d: got vld=%b data=%h need vld=%b data=%h",
                 k, spine_out_valid, spine_out_data[k*DW +: DW], 4'(1 << k), fl[k]);
      end
    end
    total++;
    if (credit_count !== 16'h3333 || busy !== 1'b0) begin
      bad++; $display("FAIL rr_credits: got cc=%h busy=%b need 3333/0", credit_count, busy);
    end
  endtask

  task automatic test_credit_exhaust_stall();
    in_valid = 1;
    for (int n = 5; n <= 17; n++) begin
      in_data = 16'(n);
      cycle();
    end
    in_valid = 0;
    total++;
    if (credit_count !== 16'h0000 || busy !== 1'b1) begin
      bad++; $display("FAIL exhaust: got cc=%h busy=%b need 0000/1", credit_count, busy);
    end
    in_valid = 1; in_data = 16'hBEEF; #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL exhaust_ready: got %b need 0", in_ready);
    end
    in_valid = 0;
    repeat (10) cycle();
    total++;
    if (stall_timeout !== 1'b0) begin
      bad++; $display("FAIL stall_early: got %b need 0", stall_timeout);
    end
    repeat (60) cycle();
    total++;
    if (stall_timeout !== 1'b1 || spine_out_valid !== 4'b0000) begin
      bad++; $display("FAIL stall_set: got to=%b vld=%b need 1/0000", stall_timeout, spine_out_valid);
    end
    credit_return = 4'b0100;
    cycle();
    credit_return = '0;
    total++;
    if (spine_out_valid !== 4'b0000 || credit_count !== 16'h0100) begin
      bad++; $display("FAIL stall_return: got vld=%b cc=%h need 0000/0100", spine_out_valid, credit_count);
    end
    cycle();
    total++;
    if (spine_out_valid !== 4'b0100 || spine_out_data[2*DW +: DW] !== 16'd17 ||
        stall_timeout !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL stall_release: got vld=%b data=%h to=%b busy=%b need 0100/0011/1/0",
               spine_out_valid, spine_out_data[2*DW +: DW], stall_timeout, busy);
    end
    credit_return = 4'b1111;
    repeat (4) cycle();
    credit_return = '0;
    total++;
    if (credit_count !== 16'h4444 || credit_overflow !== 1'b0) begin
      bad++; $display("FAIL refill: got cc=%h ov=%b need 4444/0", credit_count, credit_overflow);
    end
  endtask

  task automatic test_mask();
    int exp_g [4];
    exp_g[0] = 1; exp_g[1] = 3; exp_g[2] = 1; exp_g[3] = 3;
    enable = 0;
    apply_reset();
    enable = 1; spine_mask = 4'b0101; in_valid = 1; in_data = 16'h0100;
    cycle();
    for (int k = 0; k < 4; k++) begin
      if (k < 3) in_data = 16'h0101 + 16'(k);
      else in_valid = 0;
      cycle();
      total++;
      if (spine_out_valid !== 4'(1 << exp_g[k]) || last_grant !== 2'(exp_g[k])) begin
        bad++;
        $display("FAIL mask_grant%0d: got vld=%b lg=%0d need spine %0d", k, spine_out_valid, last_grant, exp_g[k]);
      end
    end
    total++;
    if (credit_count !== 16'h2424) begin
      bad++; $display("FAIL mask_credits: got %h need 2424", credit_count);
    end
  endtask

  task automatic test_credit_same_cycle();
    spine_mask = 4'b1101; in_valid = 1; in_data = 16'hA5A5;
    cycle();
    in_valid = 0; credit_return = 4'b0010;
    cycle();
    credit_return = '0;
    total++;
    if (spine_out_valid !== 4'b0010 || credit_count[7:4] !== 4'd2) begin
      bad++; $display("FAIL same_cycle: got vld=%b cr1=%0d need 0010/2", spine_out_valid, credit_count[7:4]);
    end
    credit_return = 4'b0001;
    cycle();
    credit_return = '0;
    total++;
    if (credit_count[3:0] !== 4'd4 || credit_overflow !== 1'b1) begin
      bad++; $display("FAIL overflow: got cr0=%0d ov=%b need 4/1", credit_count[3:0], credit_overflow);
    end
  endtask

  task automatic test_enable();
    spine_mask = '0; in_valid = 1; in_data = 16'h1234;
    cycle();
    enable = 0; in_data = 16'h5678; #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL enable_ready: got %b need 0", in_ready);
    end
    cycle();
    total++;
    if (spine_out_valid !== 4'b0100 || spine_out_data[2*DW +: DW] !== 16'h1234) begin
      bad++; $display("FAIL enable_issue: got vld=%b data=%h need 0100/1234",
                      spine_out_valid, spine_out_data[2*DW +: DW]);
    end
    for (int k = 0; k < 3; k++) begin
      cycle();
      total++;
      if (in_ready !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL enable_block%0d: got ready=%b busy=%b need 0/0", k, in_ready, busy);
      end
    end
    enable = 1; #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL enable_resume: got %b need 1", in_ready);
    end
    cycle();
    in_valid = 0;
    cycle();
  endtask

  task automatic test_reset_mid();
    spine_mask = 4'b1111; in_valid = 1; in_data = 16'h7777;
    cycle();
    in_valid = 0;
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL mid_busy: got %b need 1", busy);
    end
    #2 ARESETn = 1'b0;
    enable = 0; spine_mask = '0;
    #1;
    total++;
    if (busy !== 1'b0 || credit_count !== 16'h4444) begin
      bad++; $display("FAIL mid_async: got busy=%b cc=%h need 0/4444", busy, credit_count);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge ACLK); #1;
      total++;
      if (spine_out_valid !== 4'b0000) begin
        bad++; $display("FAIL mid_pulse%0d: got %b need 0000", k, spine_out_valid);
      end
    end
    @(negedge ACLK);
    ARESETn = 1'b1;
    model_reset();
    #1;
    total++;
    if ({in_ready, spine_out_valid, busy, stall_timeout, credit_overflow} !== '0 ||
        spine_out_data !== '0 || credit_count !== 16'h4444 || last_grant !== 2'd3) begin
      bad++;
      $display("FAIL mid_release: got ready=%b vld=%b busy=%b to=%b ov=%b data=%h cc=%h lg=%0d",
               in_ready, spine_out_valid, busy, stall_timeout, credit_overflow,
               spine_out_data, credit_count, last_grant);
    end
    enable = 1; in_valid = 1; in_data = 16'h0F0F;
    cycle();
    in_valid = 0;
    cycle();
    total++;
    if (spine_out_valid !== 4'b0001 || spine_out_data[DW-1:0] !== 16'h0F0F) begin
      bad++; $display("FAIL mid_first: got vld=%b data=%h need 0001/0f0f", spine_out_valid, spine_out_data[DW-1:0]);
    end
  endtask

  task automatic test_random();
    enable = 0; in_valid = 0; spine_mask = '0; credit_return = '0;
    apply_reset();
    for (int c = 0; c < 500; c++) begin
      enable        = ($urandom_range(0, 9) != 0);
      in_valid      = ($urandom_range(0, 3) != 0);
      in_data       = 16'($urandom);
      spine_mask    = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
      for (int i = 0; i < 4; i++) credit_return[i] = ($urandom_range(0, 4) == 0);
      #1;
      total++;
      if (in_ready !== m_ready()) begin
        bad++; $display("FAIL rnd_ready c%0d: got %b need %b", c, in_ready, m_ready());
      end
      cycle();
      total++;
      if (spine_out_valid !== m_vld || spine_out_data !== m_data_word()) begin
        bad++; $display("FAIL rnd_out c%0d: got vld=%b data=%h need vld=%b data=%h",
                        c, spine_out_valid, spine_out_data, m_vld, m_data_word());
      end
      total++;
      if (credit_count !== m_credits() || last_grant !== 2'(m_lg) || busy !== m_held ||
          stall_timeout !== m_to || credit_overflow !== m_ov) begin
        bad++;
        $display("FAIL rnd_state c%0d: got cc=%h lg=%0d busy=%b to=%b ov=%b need cc=%h lg=%0d busy=%b to=%b ov=%b",
                 c, credit_count, last_grant, busy, stall_timeout, credit_overflow,
                 m_credits(), m_lg, m_held, m_to, m_ov);
      end
    end
    in_valid = 0; credit_return = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_round_robin();
    test_credit_exhaust_stall();
    test_mask();
    test_credit_same_cycle();
    test_enable();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
